// File: rtl/mac_dot_controller_pkg.sv
// -----------------------------------------------------------------------------
// mac_ctrl_pkg
// Shared definitions for the dot-product MAC controller slice:
//   - datapath widths (operand, accumulator, job-length counter)
//   - derived maximum job length
//   - FSM state encoding (2-bit, legacy-compatible constants)
//   - vedic_2x2: the 2x2 Vedic (Urdhva Tiryagbhyam) partial multiplier used
//     to build the 4x4 multiplier
// -----------------------------------------------------------------------------
package mac_ctrl_pkg;

  // Operand width; fixed by the 4x4 multiplier.
  localparam int OPW  = 4;
  // Accumulator / result width (2 * OPW).
  localparam int ACCW = 2 * OPW;
  // Job-length counter width.
  localparam int LENW = 4;
  // Longest job the counter can express.
  localparam int MAX_LEN = (1 << LENW) - 1;

  // FSM state encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // 2x2 Vedic multiplier: vertical and crosswise partial products.
  //   p0 = x0 y0
  //   p1 = x1 y0 ^ x0 y1          (crosswise sum)
  //   c1 = x1 y0 & x0 y1          (crosswise carry)
  //   p2 = x1 y1 ^ c1, p3 = x1 y1 & c1
  function automatic logic [3:0] vedic_2x2(input logic [1:0] x, input logic [1:0] y);
    logic cross_a;
    logic cross_b;
    logic c1;
    logic hh;
    cross_a = x[1] & y[0];
    cross_b = x[0] & y[1];
    c1      = cross_a & cross_b;
    hh      = x[1] & y[1];
    return {hh & c1, hh ^ c1, cross_a ^ cross_b, x[0] & y[0]};
  endfunction

endpackage

// File: rtl/mac_dot_controller_if.sv
// -----------------------------------------------------------------------------
// mac_dot_controller_if
// Job/stream/status bundle between the tile I/O and the MAC controller.
//   start, len          job request and length (sampled together in IDLE)
//   in_valid, in_ready  operand-pair stream handshake
//   a, b                operand pair (multiplicand, multiplier)
//   busy, done          controller status; done is a one-cycle pulse
//   result, overflow    accumulator view and sticky carry-out flag
// Modports:
//   master - the side issuing jobs and operands (tile I/O, testbench)
//   slave  - the controller
// -----------------------------------------------------------------------------
interface mac_dot_controller_if;
  import mac_ctrl_pkg::*;

  logic            start;
  logic [LENW-1:0] len;
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  a;
  logic [OPW-1:0]  b;
  logic            busy;
  logic            done;
  logic [ACCW-1:0] result;
  logic            overflow;

  modport master (
    output start, len, in_valid, a, b,
    input  in_ready, busy, done, result, overflow
  );

  modport slave (
    input  start, len, in_valid, a, b,
    output in_ready, busy, done, result, overflow
  );

endinterface

// File: rtl/vedic_4x4.sv
// -----------------------------------------------------------------------------
// vedic_4x4
// Combinational 4x4 unsigned multiplier built from four 2x2 Vedic blocks.
// Ports:
//   a, b  in   4-bit unsigned operands
//   p     out  8-bit product a*b
// The four 2x2 partial products are weighted 1, 4, 4, 16 and summed.
// -----------------------------------------------------------------------------
module vedic_4x4
  import mac_ctrl_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  logic [3:0] q_ll;  // a[1:0] * b[1:0], weight 1
  logic [3:0] q_hl;  // a[3:2] * b[1:0], weight 4
  logic [3:0] q_lh;  // a[1:0] * b[3:2], weight 4
  logic [3:0] q_hh;  // a[3:2] * b[3:2], weight 16
  logic [4:0] q_mid;

  assign q_ll  = vedic_2x2(a[1:0], b[1:0]);
  assign q_hl  = vedic_2x2(a[3:2], b[1:0]);
  assign q_lh  = vedic_2x2(a[1:0], b[3:2]);
  assign q_hh  = vedic_2x2(a[3:2], b[3:2]);

  // Both middle terms share weight 4, so add them before shifting.
  assign q_mid = {1'b0, q_hl} + {1'b0, q_lh};

  // Maximum 15*15 = 225 fits in 8 bits, so no carry is lost here.
  assign p = {4'b0000, q_ll} + {1'b0, q_mid, 2'b00} + {q_hh, 4'b0000};

endmodule

// File: rtl/mac_dot_controller.sv
// -----------------------------------------------------------------------------
// mac_dot_controller
// Sequencer for a bounded, restartable dot-product job on the 4x4 multiply /
// 8-bit accumulate datapath.
// Ports:
//   clk   in  single clock, rising edge
//   rst   in  asynchronous, active-high reset (aborts any job in flight)
//   bus   slave side of mac_dot_controller_if:
//           start/len in IDLE launch a job of len operand pairs;
//           pairs arrive on a/b under in_valid/in_ready;
//           busy outside IDLE, done pulses one cycle with the final result,
//           overflow is sticky for the job.
// Pipeline: operand registers (stage 1) feed the multiplier; the accumulator
// (stage 2) adds the product whenever the operand registers hold a new pair.
// The last accept is followed by one DRAIN cycle, then one DONE cycle.
// -----------------------------------------------------------------------------
module mac_dot_controller
  import mac_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  mac_dot_controller_if.slave   bus
);

  state_t          state;
  state_t          state_nxt;
  logic [LENW-1:0] count;       // pairs still to accept in this job
  logic [OPW-1:0]  op_a;
  logic [OPW-1:0]  op_b;
  logic            op_vld;      // operand regs hold a pair not yet accumulated
  logic [ACCW-1:0] acc;
  logic            ovf;
  logic [ACCW-1:0] product;
  logic [ACCW:0]   sum;         // one extra bit to catch the carry-out
  logic            hs;          // pair accepted at the coming edge
  logic            last_hs;     // this accept completes the job's input
  logic            job_start;

  // ---------------------------------------------------------------------------
  // Status and handshake: all decoded from state only, so in_ready never
  // depends on in_valid.
  // ---------------------------------------------------------------------------
  assign bus.in_ready = (state == ST_RUN);
  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = (state == ST_DONE);
  assign bus.result   = acc;
  assign bus.overflow = ovf;

  assign hs        = bus.in_valid & bus.in_ready;
  assign last_hs   = hs && (count == LENW'(1));
  // start is only honoured in IDLE; elsewhere it is simply ignored.
  assign job_start = (state == ST_IDLE) && bus.start;

  // ---------------------------------------------------------------------------
  // Multiplier fed straight from the operand registers.
  // ---------------------------------------------------------------------------
  vedic_4x4 u_mul (
    .a (op_a),
    .b (op_b),
    .p (product)
  );

  assign sum = {1'b0, acc} + {1'b0, product};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (job_start) begin
          // A zero-length job skips straight to the done pulse.
          state_nxt = (bus.len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_hs) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      // NOTE: non-blocking assignments for every register so all state updates at the same edge.
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Counter, operand registers and accumulator
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every datapath register is reset so an aborted job leaves no partial result behind.
      count  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_vld <= 1'b0;
      acc    <= '0;
      ovf    <= 1'b0;
    end else begin
      // Stage 1: capture a pair only on a real handshake; a gap leaves
      // op_vld low so the accumulator holds.
      op_vld <= hs;
      if (hs) begin
        op_a  <= bus.a;
        op_b  <= bus.b;
        count <= count - LENW'(1);
      end

      // Stage 2. job_start (IDLE) and op_vld are never both true: the last
      // pair is accumulated at the DRAIN edge and DONE carries no pair.
      if (job_start) begin
        acc   <= '0;
        ovf   <= 1'b0;
        count <= bus.len;
      end else if (op_vld) begin
        acc <= sum[ACCW-1:0];
        ovf <= ovf | sum[ACCW];
      end
    end
  end

endmodule
